quartz_countdown: RTL and testbench



---
 rtl/quartz_countdown.sv | 155 +++++++++++++++
 tb/tb_quartz_countdown.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/quartz_countdown.sv
// -----------------------------------------------------------------------------
// quartz_countdown
//   Timer that sits downstream of the quarantine latch. While QUARTZ is held
//   high, it counts START_SEC displayed seconds, each lasting TICKS_PER_SEC
//   SLOWCLOCK cycles. On expiry it requests a latch clear with resetQUAR.
//   It holds that request until the latch acknowledges with resetFLAG. It
//   then waits in HOLD until QUARTZ has dropped, so that a stale QUARTZ level
//   cannot retrigger the timer.
//
// Ports
//   SLOWCLOCK  in   sole clock, all logic on the rising edge
//   RESET      in   synchronous, active-high reset
//   QUARTZ     in   quarantine-active level from the latch
//   resetFLAG  in   latch acknowledge (QUARTZ has been cleared)
//   resetQUAR  out  registered request to clear the latch
//   SEC_TENS   out  BCD tens digit of the remaining seconds
//   SEC_ONES   out  BCD ones digit of the remaining seconds
//   ACTIVE     out  high while counting
//   WARN       out  blinks during the final 5 seconds
// -----------------------------------------------------------------------------
module quartz_countdown #(
    parameter int TICKS_PER_SEC = 20,
    parameter int START_SEC     = 15
) (
    input  logic       SLOWCLOCK,
    input  logic       RESET,
    input  logic       QUARTZ,
    input  logic       resetFLAG,
    output logic       resetQUAR,
    output logic [3:0] SEC_TENS,
    output logic [3:0] SEC_ONES,
    output logic       ACTIVE,
    output logic       WARN
);

    localparam int TW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;

    localparam logic [TW-1:0] TICK_ZERO  = TW'(0);
    localparam logic [TW-1:0] TICK_ONE   = TW'(1);
    localparam logic [TW-1:0] TICK_LAST  = TW'(TICKS_PER_SEC - 1);
    localparam logic [TW-1:0] TICK_HALF  = TW'(TICKS_PER_SEC / 2);
    localparam logic [3:0]    START_TENS = 4'(START_SEC / 10);
    localparam logic [3:0]    START_ONES = 4'(START_SEC % 10);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_COUNT  = 2'd1,
        S_EXPIRE = 2'd2,
        S_HOLD   = 2'd3
    } state_t;

    state_t         state_q,      state_d;
    logic [TW-1:0]  tick_q,       tick_d;
    logic [3:0]     sec_tens_q,   sec_tens_d;
    logic [3:0]     sec_ones_q,   sec_ones_d;
    logic           reset_quar_q, reset_quar_d;
    logic           active_q,     active_d;
    logic           warn_q,       warn_d;

    // State register: all flops, with synchronous reset to the idle state.
    always_ff @(posedge SLOWCLOCK) begin
        if (RESET) begin
            state_q      <= S_IDLE;
            tick_q       <= TICK_ZERO;
            sec_tens_q   <= 4'd0;
            sec_ones_q   <= 4'd0;
            reset_quar_q <= 1'b0;
            active_q     <= 1'b0;
            warn_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            tick_q       <= tick_d;
            sec_tens_q   <= sec_tens_d;
            sec_ones_q   <= sec_ones_d;
            reset_quar_q <= reset_quar_d;
            active_q     <= active_d;
            warn_q       <= warn_d;
        end
    end

    // Next-state logic together with the tick counter and the BCD digits.
    always_comb begin
        state_d    = state_q;
        tick_d     = TICK_ZERO;
        sec_tens_d = 4'd0;
        sec_ones_d = 4'd0;
        case (state_q)
            S_IDLE: begin
                if (QUARTZ) begin
                    state_d    = S_COUNT;
                    sec_tens_d = START_TENS;
                    sec_ones_d = START_ONES;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_COUNT: begin
                if (!QUARTZ) begin
                    // Abort takes priority over a coincident expiry, so
                    // resetQUAR is never raised for a cancelled count.
                    state_d = S_IDLE;
                end else if (tick_q == TICK_LAST) begin
                    if ((sec_tens_q == 4'd0) && (sec_ones_q == 4'd1)) begin
                        state_d = S_EXPIRE;
                    end else if (sec_ones_q == 4'd0) begin
                        // BCD borrow: x0 -> (x-1)9
                        sec_tens_d = sec_tens_q - 4'd1;
                        sec_ones_d = 4'd9;
                    end else begin
                        sec_tens_d = sec_tens_q;
                        sec_ones_d = sec_ones_q - 4'd1;
                    end
                end else begin
                    tick_d     = tick_q + TICK_ONE;
                    sec_tens_d = sec_tens_q;
                    sec_ones_d = sec_ones_q;
                end
            end
            S_EXPIRE: begin
                if (resetFLAG) begin
                    state_d = S_HOLD;
                end else begin
                    state_d = S_EXPIRE;
                end
            end
            S_HOLD: begin
                // Leave only once QUARTZ has actually dropped.
                if (!QUARTZ) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_HOLD;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output logic: registered indicators derived from the next state.
    always_comb begin
        reset_quar_d = (state_d == S_EXPIRE);
        active_d     = (state_d == S_COUNT);
        // Blink in the first half of each second once 5 or fewer remain.
        warn_d       = (state_d == S_COUNT) && (sec_tens_d == 4'd0) &&
                       (sec_ones_d <= 4'd5) && (tick_d < TICK_HALF);
    end

    assign resetQUAR = reset_quar_q;
    assign SEC_TENS  = sec_tens_q;
    assign SEC_ONES  = sec_ones_q;
    assign ACTIVE    = active_q;
    assign WARN      = warn_q;

endmodule

// File: tb/tb_quartz_countdown.sv
// -----------------------------------------------------------------------------
// tb_quartz_countdown
//   Directed bench for quartz_countdown with TICKS_PER_SEC=4 and START_SEC=12.
//   The outputs are compared as one packed word:
//   {resetQUAR, ACTIVE, WARN, SEC_TENS, SEC_ONES}.
// -----------------------------------------------------------------------------
module tb_quartz_countdown;

    logic       SLOWCLOCK = 1'b0;
    logic       RESET     = 1'b1;
    logic       QUARTZ    = 1'b0;
    logic       resetFLAG = 1'b0;
    logic       resetQUAR;
    logic [3:0] SEC_TENS;
    logic [3:0] SEC_ONES;
    logic       ACTIVE;
    logic       WARN;

    int checks   = 0;
    int failures = 0;

    quartz_countdown #(
        .TICKS_PER_SEC(4),
        .START_SEC    (12)
    ) dut (
        .SLOWCLOCK(SLOWCLOCK),
        .RESET    (RESET),
        .QUARTZ   (QUARTZ),
        .resetFLAG(resetFLAG),
        .resetQUAR(resetQUAR),
        .SEC_TENS (SEC_TENS),
        .SEC_ONES (SEC_ONES),
        .ACTIVE   (ACTIVE),
        .WARN     (WARN)
    );

    // 10-time-unit clock period
    always #5 SLOWCLOCK = ~SLOWCLOCK;

    // Advance past one rising edge and settle before sampling or driving.
    task automatic tick();
        @(posedge SLOWCLOCK);
        #1;
    endtask

    // Behavioural latch: on an edge where resetQUAR is seen high, it clears
    // QUARTZ and raises resetFLAG; otherwise it drops resetFLAG.
    task automatic latch_tick();
        logic rq;
        rq = resetQUAR;
        @(posedge SLOWCLOCK);
        #1;
        if (rq) begin
            QUARTZ    = 1'b0;
            resetFLAG = 1'b1;
        end else begin
            resetFLAG = 1'b0;
        end
    endtask

    task automatic chk(input string tag, input logic [10:0] exp);
        logic [10:0] obs;
        obs = {resetQUAR, ACTIVE, WARN, SEC_TENS, SEC_ONES};
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Expected outputs k edges after QUARTZ was first sampled (k=0..48).
    function automatic logic [10:0] exp_count(input int k);
        int   r;
        int   t;
        logic w;
        r = 12 - (k / 4);
        t = k % 4;
        if (r == 0) begin
            return {1'b1, 1'b0, 1'b0, 4'd0, 4'd0};
        end
        w = (r <= 5) && (t < 2);
        return {1'b0, 1'b1, w, 4'(r / 10), 4'(r % 10)};
    endfunction

    // Start a count (QUARTZ already high in IDLE) and check every edge up to k=upto.
    task automatic run_count(input string tag, input int upto);
        tick();
        chk($sformatf("%s_k0", tag), exp_count(0));
        for (int k = 1; k <= upto; k++) begin
            tick();
            chk($sformatf("%s_k%0d", tag, k), exp_count(k));
        end
    endtask

    localparam logic [10:0] ZERO = 11'h000;

    initial begin
        // Reset for two edges
        RESET = 1'b1;
        tick();
        tick();
        chk("reset", ZERO);
        RESET = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("idle_%0d", i), ZERO);
        end

        // Full countdown, then the handshake with the latch model
        QUARTZ = 1'b1;
        run_count("cnt", 48);
        latch_tick();                       // edge 1
        chk("hs_e1", {1'b1, 1'b0, 1'b0, 4'd0, 4'd0});
        chk_bit("hs_e1_quartz", QUARTZ, 1'b0);
        chk_bit("hs_e1_flag", resetFLAG, 1'b1);
        latch_tick();                       // edge 2: HOLD
        chk("hs_e2", ZERO);
        latch_tick();                       // edge 3: IDLE
        chk("hs_e3", ZERO);
        chk_bit("hs_e3_flag", resetFLAG, 1'b0);
        chk_bit("hs_e3_quartz", QUARTZ, 1'b0);
        for (int i = 0; i < 4; i++) begin
            latch_tick();
            chk($sformatf("hs_noretrig_%0d", i), ZERO);
        end

        // Abort at remaining 7
        QUARTZ = 1'b1;
        run_count("abort", 20);
        chk("abort_at7", {1'b0, 1'b1, 1'b0, 4'd0, 4'd7});
        QUARTZ = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("abort_idle_%0d", i), ZERO);
        end

        // Reset during EXPIRE with no acknowledge
        QUARTZ = 1'b1;
        run_count("exp", 48);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("exp_hold_%0d", i), {1'b1, 1'b0, 1'b0, 4'd0, 4'd0});
        end
        RESET = 1'b1;
        tick();
        chk("exp_reset", ZERO);
        RESET = 1'b0;
        run_count("restart", 48);           // QUARTZ still 1 -> restart at 12

        // Acknowledge while QUARTZ stays high: HOLD must not retrigger
        resetFLAG = 1'b1;
        tick();
        chk("hold_enter", ZERO);
        resetFLAG = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("hold_stay_%0d", i), ZERO);
        end
        QUARTZ = 1'b0;
        tick();
        chk("hold_exit", ZERO);
        QUARTZ = 1'b1;
        tick();
        chk("new_start", exp_count(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
